// File: rtl/addr_gen_wr_if.sv
// addr_gen_wr_if: result-beat input and RAM write-port bundle for addr_gen_wr
//   en        start request (master -> slave)
//   i_valid   result beat valid, i_data result word (master -> slave)
//   o_wr_en, o_wr_addr, o_wr_data   registered RAM write port (slave -> master)
//   o_busy, o_done, o_ovf           status (slave -> master)
interface addr_gen_wr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  en;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_ovf;
    modport master (
        output en, i_valid, i_data,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_ovf
    );
    modport slave (
        input  en, i_valid, i_data,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_ovf
    );
endinterface

// File: rtl/addr_gen_wr.sv
// addr_gen_wr: write-side address generator, writes one result word per beat from BASE to STOP
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       addr_gen_wr_if.slave: en/i_valid/i_data in; registered write port and busy/done/ovf out
//   ADDR_GEN_WR_OVF_EN  when defined, o_ovf flags beats dropped in IDLE/DONE (sticky); otherwise o_ovf is 0
module addr_gen_wr #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BASE       = 0,
    parameter int STOP       = 53
) (
    input logic          clk,
    input logic          rst,
    addr_gen_wr_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] base_a = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] stop_a = ADDR_WIDTH'(STOP);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    // busy/done are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= base_a;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (bus.en) begin
                        state <= WRITE;
                        addr  <= base_a;
                        busy  <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_en <= bus.i_valid;
                    if (bus.i_valid) begin
                        wr_addr <= addr;
                        wr_data <= bus.i_data;
                        addr    <= addr + 1'b1;
                        if (addr == stop_a) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.o_wr_en   = wr_en;
    assign bus.o_wr_addr = wr_addr;
    assign bus.o_wr_data = wr_data;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
`ifdef ADDR_GEN_WR_OVF_EN
    logic ovf;
    // an accepted start clears the flag even if a beat is dropped in the same cycle
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && bus.en))
            ovf <= 1'b0;
        else if (state != WRITE && bus.i_valid)
            ovf <= 1'b1;
    end
    assign bus.o_ovf = ovf;
`else
    assign bus.o_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_addr_gen_wr.sv
// tb_addr_gen_wr: randomized scoreboard bench for addr_gen_wr (default pass and a wrapping 4-bit pass)
module tb_addr_gen_wr;
`ifdef ADDR_GEN_WR_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic v = 1'b0;
    logic [15:0] d = '0;
    always #5 clk = ~clk;

    addr_gen_wr_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) b0 ();
    addr_gen_wr_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(16)) b1 ();
    addr_gen_wr #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .BASE(0),  .STOP(53)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    addr_gen_wr #(.ADDR_WIDTH(4),  .DATA_WIDTH(16), .BASE(14), .STOP(1))  d1 (.clk(clk), .rst(rst), .bus(b1.slave));
    assign b0.en = en;
    assign b0.i_valid = v;
    assign b0.i_data = d;
    assign b1.en = en;
    assign b1.i_valid = v;
    assign b1.i_data = d;

    logic [1:0] we, dn, bz, ov;
    logic [11:0] wa [2];
    logic [15:0] wd [2];
    assign we = {b1.o_wr_en, b0.o_wr_en};
    assign dn = {b1.o_done, b0.o_done};
    assign bz = {b1.o_busy, b0.o_busy};
    assign ov = {b1.o_ovf, b0.o_ovf};
    assign wa[0] = b0.o_wr_addr;
    assign wa[1] = {8'd0, b1.o_wr_addr};
    assign wd[0] = b0.o_wr_data;
    assign wd[1] = b1.o_wr_data;

    typedef struct {int addr; int data; bit last;} wr_t;
    wr_t q0[$];
    wr_t q1[$];
    int ph[2];
    int k[2];
    bit xov[2];
    int total = 0;
    int passed = 0;

    function automatic int aw(int i);   return i ? 4 : 12;  endfunction
    function automatic int base(int i); return i ? 14 : 0;  endfunction
    function automatic int stop(int i); return i ? 1 : 53;  endfunction
    function automatic int nb(int i);
        return ((stop(i) - base(i) + (1 << aw(i))) % (1 << aw(i))) + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // reference: phase 0 idle, 1 accepting beats, 2 end-of-pass cycle; k counts beats in the pass
    task automatic model(input bit r, input bit e_s, input bit v_s, input int d_s);
        wr_t w;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                ph[i] = 0; k[i] = 0; xov[i] = 0;
            end else if (ph[i] == 0) begin
                if (e_s) begin ph[i] = 1; k[i] = 0; xov[i] = 0; end
                else if (v_s) xov[i] = OVF;
            end else if (ph[i] == 1) begin
                if (v_s) begin
                    w.addr = (base(i) + k[i]) % (1 << aw(i));
                    w.data = d_s;
                    w.last = (k[i] == nb(i) - 1);
                    if (i == 0) q0.push_back(w); else q1.push_back(w);
                    k[i]++;
                    if (w.last) ph[i] = 2;
                end
            end else begin
                if (v_s) xov[i] = OVF;
                ph[i] = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit e_, input bit v_, input int d_);
        rst = r; en = e_; v = v_; d = 16'(d_);
        @(posedge clk);
        model(r, e_, v_, d_ & 16'hffff);
        #1;
    endtask

    task automatic mon(input int i, input bit h, input wr_t e);
        chk($sformatf("wr_en%0d", i), int'(we[i]), int'(h));
        if (h && we[i]) begin
            chk($sformatf("wr_addr%0d", i), int'(wa[i]), e.addr);
            chk($sformatf("wr_data%0d", i), int'(wd[i]), e.data);
            chk($sformatf("done_with_last%0d", i), int'(dn[i]), int'(e.last));
        end
        chk($sformatf("busy%0d", i), int'(bz[i]), int'(ph[i] != 0));
        chk($sformatf("done%0d", i), int'(dn[i]), int'(ph[i] == 2));
        chk($sformatf("ovf%0d", i), int'(ov[i]), int'(xov[i]));
    endtask

    always @(negedge clk) begin
        wr_t e0, e1;
        bit h0, h1;
        e0 = '{0, 0, 1'b0};
        e1 = '{0, 0, 1'b0};
        h0 = q0.size() > 0;
        h1 = q1.size() > 0;
        if (h0) e0 = q0.pop_front();
        if (h1) e1 = q1.pop_front();
        mon(0, h0, e0);
        mon(1, h1, e1);
    end

    task automatic reset_check();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_wr_en%0d", i), int'(we[i]), 0);
            chk($sformatf("rst_wr_addr%0d", i), int'(wa[i]), 0);
            chk($sformatf("rst_wr_data%0d", i), int'(wd[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(bz[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(dn[i]), 0);
            chk($sformatf("rst_ovf%0d", i), int'(ov[i]), 0);
        end
    endtask

    task automatic finish_pass();
        for (int n = 0; n < 300 && ph[0] != 0; n++) step(0, 0, 1, $urandom_range(0, 65535));
        chk("pass_finished", ph[0], 0);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        reset_check();
        step(0, 1, 0, 0);
        for (int a = 0; a < 54; a++) step(0, 0, 1, a + 100);
        for (int n = 0; n < 3; n++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 11);
        step(0, 0, 0, 22);
        step(0, 0, 0, 33);
        step(0, 0, 1, 44);
        step(0, 0, 1, 55);
        finish_pass();
        step(0, 0, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("ovf_idle_beat", int'(b0.o_ovf), int'(OVF));
        step(0, 1, 1, 7);
        @(negedge clk);
        chk("ovf_cleared_on_start", int'(b0.o_ovf), 0);
        chk("start_beat_dropped", int'(b0.o_wr_en), 0);
        finish_pass();
        for (int n = 0; n < 130; n++) step(0, 1, 1, $urandom_range(0, 65535));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        finish_pass();
        step(0, 1, 0, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 1, n + 900);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        reset_check();
        step(0, 1, 0, 0);
        for (int n = 0; n < 3; n++) step(0, 0, 1, n + 700);
        finish_pass();
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 65535));
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
